// File: rtl/calc_rs.sv
// Reservation station with a single-cycle ALU for LUI/AUIPC/R-type/I-type calc instructions.
// Optional macro CALC_RS_WAKEUP_BYPASS_EN forwards same-cycle CDB values straight into select/ALU.
module calc_rs #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int TYPE_W = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              in_valid,
    input  logic [TYPE_W-1:0] in_type,
    input  logic [31:0]       in_vj,
    input  logic [31:0]       in_vk,
    input  logic              in_qj_valid,
    input  logic              in_qk_valid,
    input  logic [TAG_W-1:0]  in_qj,
    input  logic [TAG_W-1:0]  in_qk,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_pc,
    input  logic [TAG_W-1:0]  in_rob_tag,
    output logic              full,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [31:0]       cdb0_value,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [31:0]       cdb1_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [31:0]       out_value
);

    localparam int IDX_W = $clog2(DEPTH);

    // Instruction type codes shared with the decoder.
    localparam logic [TYPE_W-1:0] TYPE_LUI   = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_AUIPC = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TYPE_ADDI  = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] TYPE_SLTI  = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] TYPE_SLTIU = TYPE_W'(5);
    localparam logic [TYPE_W-1:0] TYPE_XORI  = TYPE_W'(6);
    localparam logic [TYPE_W-1:0] TYPE_ORI   = TYPE_W'(7);
    localparam logic [TYPE_W-1:0] TYPE_ANDI  = TYPE_W'(8);
    localparam logic [TYPE_W-1:0] TYPE_SLLI  = TYPE_W'(9);
    localparam logic [TYPE_W-1:0] TYPE_SRLI  = TYPE_W'(10);
    localparam logic [TYPE_W-1:0] TYPE_SRAI  = TYPE_W'(11);
    localparam logic [TYPE_W-1:0] TYPE_ADD   = TYPE_W'(12);
    localparam logic [TYPE_W-1:0] TYPE_SUB   = TYPE_W'(13);
    localparam logic [TYPE_W-1:0] TYPE_SLL   = TYPE_W'(14);
    localparam logic [TYPE_W-1:0] TYPE_SLT   = TYPE_W'(15);
    localparam logic [TYPE_W-1:0] TYPE_SLTU  = TYPE_W'(16);
    localparam logic [TYPE_W-1:0] TYPE_XOR   = TYPE_W'(17);
    localparam logic [TYPE_W-1:0] TYPE_SRL   = TYPE_W'(18);
    localparam logic [TYPE_W-1:0] TYPE_SRA   = TYPE_W'(19);
    localparam logic [TYPE_W-1:0] TYPE_OR    = TYPE_W'(20);
    localparam logic [TYPE_W-1:0] TYPE_AND   = TYPE_W'(21);

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_qj_valid;
    logic [DEPTH-1:0]  ent_qk_valid;
    logic [TYPE_W-1:0] ent_type [DEPTH];
    logic [31:0]       ent_vj   [DEPTH];
    logic [31:0]       ent_vk   [DEPTH];
    logic [31:0]       ent_imm  [DEPTH];
    logic [31:0]       ent_pc   [DEPTH];
    logic [TAG_W-1:0]  ent_qj   [DEPTH];
    logic [TAG_W-1:0]  ent_qk   [DEPTH];
    logic [TAG_W-1:0]  ent_tag  [DEPTH];

    logic [DEPTH-1:0]  hit_j;
    logic [DEPTH-1:0]  hit_k;
    logic [31:0]       wake_vj [DEPTH];
    logic [31:0]       wake_vk [DEPTH];
    logic [DEPTH-1:0]  ready_j;
    logic [DEPTH-1:0]  ready_k;
    logic [DEPTH-1:0]  cand;
    logic              sel_any;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  free_idx;
    logic [31:0]       sel_vj;
    logic [31:0]       sel_vk;
    logic [31:0]       sel_result;
    logic              out_free;
    logic              in_hit_j;
    logic              in_hit_k;
    logic [31:0]       in_cap_vj;
    logic [31:0]       in_cap_vk;

    function automatic logic [31:0] alu(
        input logic [TYPE_W-1:0] op,
        input logic [31:0]       a,
        input logic [31:0]       b,
        input logic [31:0]       imm,
        input logic [31:0]       pc
    );
        logic [31:0] r;
        case (op)
            TYPE_LUI:   r = imm;
            TYPE_AUIPC: r = pc + imm;
            TYPE_ADDI:  r = a + imm;
            TYPE_SLTI:  r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            TYPE_SLTIU: r = (a < imm) ? 32'd1 : 32'd0;
            TYPE_XORI:  r = a ^ imm;
            TYPE_ORI:   r = a | imm;
            TYPE_ANDI:  r = a & imm;
            TYPE_SLLI:  r = a << imm[4:0];
            TYPE_SRLI:  r = a >> imm[4:0];
            TYPE_SRAI:  r = $signed(a) >>> imm[4:0];
            TYPE_ADD:   r = a + b;
            TYPE_SUB:   r = a - b;
            TYPE_SLL:   r = a << b[4:0];
            TYPE_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            TYPE_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            TYPE_XOR:   r = a ^ b;
            TYPE_SRL:   r = a >> b[4:0];
            TYPE_SRA:   r = $signed(a) >>> b[4:0];
            TYPE_OR:    r = a | b;
            TYPE_AND:   r = a & b;
            default:    r = 32'd0;
        endcase
        return r;
    endfunction

    // Per-entry CDB snoop; cdb0 takes precedence when both buses carry the same tag.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit_j[i]   = ent_qj_valid[i] &&
                         ((cdb0_valid && cdb0_tag == ent_qj[i]) || (cdb1_valid && cdb1_tag == ent_qj[i]));
            hit_k[i]   = ent_qk_valid[i] &&
                         ((cdb0_valid && cdb0_tag == ent_qk[i]) || (cdb1_valid && cdb1_tag == ent_qk[i]));
            wake_vj[i] = (cdb0_valid && cdb0_tag == ent_qj[i]) ? cdb0_value : cdb1_value;
            wake_vk[i] = (cdb0_valid && cdb0_tag == ent_qk[i]) ? cdb0_value : cdb1_value;
        end
    end

    always_comb begin
        in_hit_j  = in_qj_valid &&
                    ((cdb0_valid && cdb0_tag == in_qj) || (cdb1_valid && cdb1_tag == in_qj));
        in_hit_k  = in_qk_valid &&
                    ((cdb0_valid && cdb0_tag == in_qk) || (cdb1_valid && cdb1_tag == in_qk));
        in_cap_vj = (cdb0_valid && cdb0_tag == in_qj) ? cdb0_value : cdb1_value;
        in_cap_vk = (cdb0_valid && cdb0_tag == in_qk) ? cdb0_value : cdb1_value;
    end

`ifdef CALC_RS_WAKEUP_BYPASS_EN
    assign ready_j = ~ent_qj_valid | hit_j;
    assign ready_k = ~ent_qk_valid | hit_k;
`else
    assign ready_j = ~ent_qj_valid;
    assign ready_k = ~ent_qk_valid;
`endif

    assign cand     = ent_valid & ready_j & ready_k;
    assign sel_any  = |cand;
    assign full     = &ent_valid;
    assign out_free = !out_valid || out_ready;

    // Lowest-index priority encoders for selection and for the issue slot.
    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_idx = IDX_W'(i);
            end
            if (!ent_valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef CALC_RS_WAKEUP_BYPASS_EN
    assign sel_vj = ent_qj_valid[sel_idx] ? wake_vj[sel_idx] : ent_vj[sel_idx];
    assign sel_vk = ent_qk_valid[sel_idx] ? wake_vk[sel_idx] : ent_vk[sel_idx];
`else
    assign sel_vj = ent_vj[sel_idx];
    assign sel_vk = ent_vk[sel_idx];
`endif

    assign sel_result = alu(ent_type[sel_idx], sel_vj, sel_vk, ent_imm[sel_idx], ent_pc[sel_idx]);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ent_valid <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_value <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                ent_valid <= '0;
                out_valid <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_valid[i] && hit_j[i]) begin
                        ent_vj[i]       <= wake_vj[i];
                        ent_qj_valid[i] <= 1'b0;
                    end
                    if (ent_valid[i] && hit_k[i]) begin
                        ent_vk[i]       <= wake_vk[i];
                        ent_qk_valid[i] <= 1'b0;
                    end
                end

                if (out_free) begin
                    out_valid <= sel_any;
                    if (sel_any) begin
                        ent_valid[sel_idx] <= 1'b0;
                        out_tag            <= ent_tag[sel_idx];
                        out_value          <= sel_result;
                    end
                end

                // free_idx comes from the pre-edge valid bits, so a slot freed this cycle is not reused yet.
                if (in_valid && !full) begin
                    ent_valid[free_idx]    <= 1'b1;
                    ent_type[free_idx]     <= in_type;
                    ent_imm[free_idx]      <= in_imm;
                    ent_pc[free_idx]       <= in_pc;
                    ent_tag[free_idx]      <= in_rob_tag;
                    ent_qj[free_idx]       <= in_qj;
                    ent_qk[free_idx]       <= in_qk;
                    ent_vj[free_idx]       <= in_hit_j ? in_cap_vj : in_vj;
                    ent_vk[free_idx]       <= in_hit_k ? in_cap_vk : in_vk;
                    ent_qj_valid[free_idx] <= in_qj_valid && !in_hit_j;
                    ent_qk_valid[free_idx] <= in_qk_valid && !in_hit_k;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_rs.sv
// Directed self-checking bench for calc_rs; expectations follow the CALC_RS_WAKEUP_BYPASS_EN build setting.
module tb_calc_rs;

    localparam logic [5:0] T_LUI   = 6'd1;
    localparam logic [5:0] T_AUIPC = 6'd2;
    localparam logic [5:0] T_ADDI  = 6'd3;
    localparam logic [5:0] T_SLTI  = 6'd4;
    localparam logic [5:0] T_XORI  = 6'd6;
    localparam logic [5:0] T_ORI   = 6'd7;
    localparam logic [5:0] T_ANDI  = 6'd8;
    localparam logic [5:0] T_SLLI  = 6'd9;
    localparam logic [5:0] T_SRAI  = 6'd11;
    localparam logic [5:0] T_ADD   = 6'd12;
    localparam logic [5:0] T_SUB   = 6'd13;
    localparam logic [5:0] T_SLL   = 6'd14;
    localparam logic [5:0] T_SLT   = 6'd15;
    localparam logic [5:0] T_SLTU  = 6'd16;
    localparam logic [5:0] T_SRL   = 6'd18;
    localparam logic [5:0] T_SRA   = 6'd19;
    localparam logic [5:0] T_OR    = 6'd20;

`ifdef CALC_RS_WAKEUP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        in_valid;
    logic [5:0]  in_type;
    logic [31:0] in_vj, in_vk, in_imm, in_pc;
    logic        in_qj_valid, in_qk_valid;
    logic [3:0]  in_qj, in_qk, in_rob_tag;
    logic        full;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_value, cdb1_value;
    logic        out_valid, out_ready;
    logic [3:0]  out_tag;
    logic [31:0] out_value;

    int n_cmp = 0;
    int n_fail = 0;

    calc_rs dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_type(in_type), .in_vj(in_vj), .in_vk(in_vk),
        .in_qj_valid(in_qj_valid), .in_qk_valid(in_qk_valid), .in_qj(in_qj), .in_qk(in_qk),
        .in_imm(in_imm), .in_pc(in_pc), .in_rob_tag(in_rob_tag), .full(full),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_value(out_value)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] ty, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjv, input logic [3:0] qj, input logic qkv, input logic [3:0] qk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        in_valid = 1'b1; in_type = ty; in_vj = vj; in_vk = vk;
        in_qj_valid = qjv; in_qj = qj; in_qk_valid = qkv; in_qk = qk;
        in_imm = imm; in_pc = pc; in_rob_tag = tag;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_qj_valid = 1'b0; in_qk_valid = 1'b0;
    endtask

    task automatic cdb_clear();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (out_tag !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_out_tag: got %0d want 0", out_tag); end
        n_cmp++; if (out_value !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_out_value: got %h want 0", out_value); end
        issue(T_ADDI, 32'd5, 32'hDEAD0000, 1'b0, 4'd0, 1'b0, 4'd0, 32'd7, 32'd0, 4'd3);
        tick(); idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL addi_n1_valid: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_n2_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_tag !== 4'd3) begin n_fail++; $display("[TB] FAIL addi_tag: got %0d want 3", out_tag); end
        n_cmp++; if (out_value !== 32'd12) begin n_fail++; $display("[TB] FAIL addi_value: got %h want 0000000c", out_value); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL addi_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_dependency();
        // SUB waits on tag 2 for vj; an unrelated broadcast first must not wake it.
        issue(T_SUB, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 32'd0, 4'd4);
        tick(); idle();
        cdb0_valid = 1'b1; cdb0_tag = 4'd3; cdb0_value = 32'd77;
        tick(); cdb_clear();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dep_wrong_tag: got %b want 0", out_valid); end
        cdb1_valid = 1'b1; cdb1_tag = 4'd2; cdb1_value = 32'd10;
        tick(); cdb_clear();
        n_cmp++; if (out_valid !== BYP) begin n_fail++; $display("[TB] FAIL dep_m1_valid: got %b want %b", out_valid, BYP); end
        tick();
        n_cmp++; if (out_valid !== !BYP) begin n_fail++; $display("[TB] FAIL dep_m2_valid: got %b want %b", out_valid, !BYP); end
        n_cmp++; if (out_tag !== 4'd4) begin n_fail++; $display("[TB] FAIL dep_tag: got %0d want 4", out_tag); end
        n_cmp++; if (out_value !== 32'd9) begin n_fail++; $display("[TB] FAIL dep_value: got %h want 00000009", out_value); end
        tick();
        // Both buses broadcast tag 7 at once; cdb0's value must be used.
        issue(T_ADD, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd7, 32'd0, 32'd0, 4'd5);
        tick(); idle();
        cdb0_valid = 1'b1; cdb0_tag = 4'd7; cdb0_value = 32'd20;
        cdb1_valid = 1'b1; cdb1_tag = 4'd7; cdb1_value = 32'd50;
        tick(); cdb_clear();
        tick();
        n_cmp++; if (out_tag !== 4'd5) begin n_fail++; $display("[TB] FAIL prio_tag: got %0d want 5", out_tag); end
        n_cmp++; if (out_value !== 32'd21) begin n_fail++; $display("[TB] FAIL prio_value: got %h want 00000015", out_value); end
        tick(); tick();
    endtask

    task automatic test_capture();
        issue(T_OR, 32'd0, 32'd1, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 32'd0, 4'd6);
        cdb0_valid = 1'b1; cdb0_tag = 4'd5; cdb0_value = 32'h40;
        tick(); idle(); cdb_clear();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL cap_n1_valid: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL cap_n2_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_tag !== 4'd6) begin n_fail++; $display("[TB] FAIL cap_tag: got %0d want 6", out_tag); end
        n_cmp++; if (out_value !== 32'h41) begin n_fail++; $display("[TB] FAIL cap_value: got %h want 00000041", out_value); end
        tick();
    endtask

    task automatic test_arith();
        logic [5:0]  ty  [16];
        logic [31:0] a   [16];
        logic [31:0] b   [16];
        logic [31:0] im  [16];
        logic [31:0] pc  [16];
        logic [31:0] exp [16];
        ty[0]  = T_SRA;   a[0]  = 32'h80000000; b[0]  = 32'd4;        im[0]  = 32'd0;        pc[0]  = 32'd0;      exp[0]  = 32'hF8000000;
        ty[1]  = T_SLTU;  a[1]  = 32'd1;        b[1]  = 32'hFFFFFFFF; im[1]  = 32'd0;        pc[1]  = 32'd0;      exp[1]  = 32'd1;
        ty[2]  = T_SLT;   a[2]  = 32'd1;        b[2]  = 32'hFFFFFFFF; im[2]  = 32'd0;        pc[2]  = 32'd0;      exp[2]  = 32'd0;
        ty[3]  = T_ADD;   a[3]  = 32'hFFFFFFFF; b[3]  = 32'd1;        im[3]  = 32'd0;        pc[3]  = 32'd0;      exp[3]  = 32'd0;
        ty[4]  = T_AUIPC; a[4]  = 32'd0;        b[4]  = 32'h0BADF00D; im[4]  = 32'h2000;     pc[4]  = 32'h1000;   exp[4]  = 32'h3000;
        ty[5]  = T_SRL;   a[5]  = 32'h80000000; b[5]  = 32'd4;        im[5]  = 32'd0;        pc[5]  = 32'd0;      exp[5]  = 32'h08000000;
        ty[6]  = T_SLLI;  a[6]  = 32'd1;        b[6]  = 32'd3;        im[6]  = 32'd31;       pc[6]  = 32'd0;      exp[6]  = 32'h80000000;
        ty[7]  = T_SUB;   a[7]  = 32'd0;        b[7]  = 32'd1;        im[7]  = 32'd0;        pc[7]  = 32'd0;      exp[7]  = 32'hFFFFFFFF;
        ty[8]  = T_XORI;  a[8]  = 32'hF0F0F0F0; b[8]  = 32'd0;        im[8]  = 32'hFFFFFFFF; pc[8]  = 32'd0;      exp[8]  = 32'h0F0F0F0F;
        ty[9]  = T_ANDI;  a[9]  = 32'h12345678; b[9]  = 32'hFFFFFFFF; im[9]  = 32'h0000FF00; pc[9]  = 32'd0;      exp[9]  = 32'h00005600;
        ty[10] = T_LUI;   a[10] = 32'h11111111; b[10] = 32'h22222222; im[10] = 32'hABCDE000; pc[10] = 32'h400;    exp[10] = 32'hABCDE000;
        ty[11] = 6'd63;   a[11] = 32'd5;        b[11] = 32'd5;        im[11] = 32'd5;        pc[11] = 32'd0;      exp[11] = 32'd0;
        ty[12] = T_SRAI;  a[12] = 32'h80000000; b[12] = 32'd0;        im[12] = 32'd36;       pc[12] = 32'd0;      exp[12] = 32'hF8000000;
        ty[13] = T_SLTI;  a[13] = 32'hFFFFFFFF; b[13] = 32'd0;        im[13] = 32'd0;        pc[13] = 32'd0;      exp[13] = 32'd1;
        ty[14] = T_SLL;   a[14] = 32'd1;        b[14] = 32'h21;       im[14] = 32'd0;        pc[14] = 32'd0;      exp[14] = 32'd2;
        ty[15] = T_ORI;   a[15] = 32'h100;      b[15] = 32'd0;        im[15] = 32'h0F;       pc[15] = 32'd0;      exp[15] = 32'h10F;
        // Back-to-back issue: op k appears two cycles after its issue, one result per cycle.
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) issue(ty[k], a[k], b[k], 1'b0, 4'd0, 1'b0, 4'd0, im[k], pc[k], 4'(k));
            else idle();
            tick();
            if (k >= 1) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL arith%0d_valid: got %b want 1", k - 1, out_valid); end
                n_cmp++; if (out_tag !== 4'(k - 1)) begin n_fail++; $display("[TB] FAIL arith%0d_tag: got %0d want %0d", k - 1, out_tag, k - 1); end
                n_cmp++; if (out_value !== exp[k - 1]) begin n_fail++; $display("[TB] FAIL arith%0d_value: got %h want %h", k - 1, out_value, exp[k - 1]); end
            end
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arith_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(T_ADDI, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h55, 32'd0, 4'd15);
        tick(); idle();
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'd15) begin n_fail++; $display("[TB] FAIL bp_head: got v=%b tag=%0d want v=1 tag=15", out_valid, out_tag); end
        for (int i = 0; i < 8; i++) begin
            issue(T_ADDI, 32'(i), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd100, 32'd0, 4'(i));
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'd15 || out_value !== 32'h55) begin
                n_fail++; $display("[TB] FAIL bp_hold%0d: got v=%b tag=%0d val=%h want v=1 tag=15 val=00000055", i, out_valid, out_tag, out_value);
            end
        end
        idle();
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_full: got %b want 1", full); end
        issue(T_ADDI, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd999, 32'd0, 4'd9);
        tick(); idle();
        n_cmp++; if (full !== 1'b1 || out_tag !== 4'd15) begin n_fail++; $display("[TB] FAIL bp_extra: got full=%b tag=%0d want full=1 tag=15", full, out_tag); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'(i) || out_value !== 32'(100 + i)) begin
                n_fail++; $display("[TB] FAIL bp_drain%0d: got v=%b tag=%0d val=%h want v=1 tag=%0d val=%h", i, out_valid, out_tag, out_value, i, 32'(100 + i));
            end
            if (i == 0) begin
                n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_unfull: got %b want 0", full); end
            end
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_no_extra: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(T_ADDI, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'(i), 32'd0, 4'(i));
            tick();
        end
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'd1) begin n_fail++; $display("[TB] FAIL fl_pre: got v=%b tag=%0d want v=1 tag=1", out_valid, out_tag); end
        issue(T_ADDI, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd5, 32'd0, 4'd5);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; idle(); out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_valid: got %b want 0", out_valid); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_full: got %b want 0", full); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_quiet%0d: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(T_ADDI, 32'(k), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1, 32'd0, 4'(10 + k));
            tick();
        end
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'd11 || out_value !== 32'd2) begin
            n_fail++; $display("[TB] FAIL st_pre: got v=%b tag=%0d val=%h want v=1 tag=11 val=00000002", out_valid, out_tag, out_value);
        end
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'd11 || out_value !== 32'd2) begin
                n_fail++; $display("[TB] FAIL st_frozen%0d: got v=%b tag=%0d val=%h want v=1 tag=11 val=00000002", i, out_valid, out_tag, out_value);
            end
        end
        rdy_in = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'd12 || out_value !== 32'd3) begin
            n_fail++; $display("[TB] FAIL st_resume: got v=%b tag=%0d val=%h want v=1 tag=12 val=00000003", out_valid, out_tag, out_value);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL st_done: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_priority();
        out_ready = 1'b0;
        issue(T_ADDI, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd8, 32'd0, 4'd8);
        tick();
        issue(T_ADDI, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd9, 32'd0, 4'd9);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_tag !== 4'd8) begin n_fail++; $display("[TB] FAIL rp_pre: got v=%b tag=%0d want v=1 tag=8", out_valid, out_tag); end
        rdy_in = 1'b0; rst_in = 1'b1;
        tick();
        rst_in = 1'b0; rdy_in = 1'b1; idle(); out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || out_tag !== 4'd0 || out_value !== 32'd0 || full !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rp_cleared: got v=%b tag=%0d val=%h full=%b want all 0", out_valid, out_tag, out_value, full);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rp_quiet%0d: got %b want 0", i, out_valid); end
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_type = 6'd0; in_vj = 32'd0; in_vk = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
        in_qj_valid = 1'b0; in_qk_valid = 1'b0; in_qj = 4'd0; in_qk = 4'd0; in_rob_tag = 4'd0;
        cdb0_valid = 1'b0; cdb0_tag = 4'd0; cdb0_value = 32'd0;
        cdb1_valid = 1'b0; cdb1_tag = 4'd0; cdb1_value = 32'd0;
        test_reset();
        test_dependency();
        test_capture();
        test_arith();
        test_backpressure();
        test_flush();
        test_stall();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_rs.md
Name: calc_rs

Overview:
- Reservation station plus single-cycle ALU for calc-class instructions: LUI, AUIPC, R-type ALU ops and I-type ALU ops.
- Sits between the dispatcher and the CDB. The dispatcher routes every instruction classified as calc into this block.
- Holds operands until their producer tags appear on the CDBs, selects one ready entry per cycle, computes the result and presents it to the CDB arbiter.

Parameters:
- DEPTH, 8, number of RS entries; power of two, at least 2.
- TAG_W, 4, ROB index width.
- TYPE_W, 6, instruction-type code width; codes are the info.v macros.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global enable; when low, no state changes.
- flush_in  input  1  mispredict clear.
- in_valid  input  1  dispatch writes one entry.
- in_type  input  TYPE_W  instruction type code.
- in_vj, in_vk  input  32  operand values.
- in_qj_valid, in_qk_valid  input  1  operand still pending.
- in_qj, in_qk  input  TAG_W  producer tags.
- in_imm  input  32  immediate; LUI/AUIPC values are pre-shifted.
- in_pc  input  32  instruction PC.
- in_rob_tag  input  TAG_W  destination ROB entry.
- full  output  1  all entries valid.
- cdb0_valid, cdb1_valid  input  1  broadcast strobes (ALU bus, LSB bus).
- cdb0_tag, cdb1_tag  input  TAG_W  broadcast tags.
- cdb0_value, cdb1_value  input  32  broadcast values.
- out_valid  output  1  result available.
- out_ready  input  1  arbiter accepts the result.
- out_tag  output  TAG_W  ROB tag of the result.
- out_value  output  32  computed result.

Behaviour:
- Reset (rst_in=1 at an edge): all entries invalid; out_valid=0, out_tag=0, out_value=0; full=0. Reset mid-operation discards everything and has priority over flush, rdy_in and issue.
- rdy_in=0: every register holds. Outputs keep their values.
- Flush: flush_in=1 invalidates all entries and clears out_valid at the edge. It overrides in_valid and selection in that cycle.
- full: combinational, equal to the AND of the entry valid bits.
- Issue:
  - in_valid while full=0 writes the lowest-index free entry.
  - in_valid while full=1 is a protocol violation; the entry is dropped and the block state is unchanged.
  - An entry freed in the same cycle is not visible to issue until the next cycle.
- Issue-cycle capture: if a pending in_q matches a valid cdbX_tag in the issue cycle, store cdbX_value and mark the operand ready.
- Wakeup: each cycle, every valid entry's pending operand compares against both CDBs. On a match it latches the value and clears q. If both CDBs match the same tag, cdb0 wins.
- Select:
  - Candidate entries are valid with both operands ready.
  - The lowest index is chosen when the output stage is free, i.e. out_valid=0 or out_ready=1.
  - The chosen entry is freed and its result is registered. Next cycle out_valid=1.
  - If out_valid=1 and out_ready=0, there is no selection and out_* hold stable.
  - out_valid drops after acceptance unless a new result loads in the same cycle, which allows back-to-back results.
- Latency: issue with ready operands in cycle N -> selected in N+1 -> out_valid in N+2.
- ALU (32-bit wrap-around):
  - Add and subtract: ADD/ADDI = vj+vk or vj+imm; SUB = vj-vk.
  - Shifts use amount [4:0] of vk or imm: SLL/SLLI; SRL/SRLI logical; SRA/SRAI arithmetic.
  - Comparisons: SLT/SLTI signed; SLTU/SLTIU unsigned; result 1 or 0.
  - Logic: XOR, OR, AND and their I forms.
  - LUI = imm; AUIPC = pc+imm.
  - Any non-calc type yields 0. The tag is still reported, so the ROB is not deadlocked.
- I-type and LUI/AUIPC are dispatched with in_qk_valid=0; their vk is ignored.

Optional Feature:
- Macro: CALC_RS_WAKEUP_BYPASS_EN.
- Defined: select logic treats an operand as ready when a CDB match occurs in the same cycle, forwarding cdb value into the ALU. This saves one cycle: CDB broadcast in cycle M -> out_valid in M+1.
- Undefined: the wakeup value is latched at the edge; the entry is selectable in M+1 and out_valid is asserted in M+2.
- Issue-cycle capture applies in both builds.

Test Plan:
- Reset: after rst_in pulse -> out_valid=0, full=0. Issue ADDI vj=5 imm=7 tag=3 -> out_valid at N+2, out_tag=3, out_value=12.
- Dependency: issue SUB with qj=2 pending, vk=1; cdb1 tag=2 value=10 in cycle M -> out_value=9. out_valid at M+2, or M+1 with bypass.
- Backpressure and full: issue DEPTH ready ops with out_ready=0 -> full=1, out_* stable. An extra in_valid is ignored. Raising out_ready drains one result per cycle in index order.
- Edge arithmetic: SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1,0xFFFFFFFF -> 1; SLT 1,0xFFFFFFFF -> 0; ADD 0xFFFFFFFF+1 -> 0; AUIPC pc=0x1000 imm=0x2000 -> 0x3000.
- Issue-cycle capture: issue with qj=5 while cdb0 broadcasts tag 5 value 0x40 in the same cycle, vk=1, type OR -> out_value=0x41.
- Flush: with 3 entries valid and out_valid=1, pulse flush_in -> next cycle out_valid=0, full=0, and no later result is emitted. rdy_in=0 for 3 cycles mid-stream -> out_* frozen.
